// File: rtl/nlc_ch_scheduler.sv
// Round-robin sequencer that time-shares one NLC evaluation core between NCH ADC channels.
// Holds one pending sample per channel; a sample lost to a newer one sets a sticky overrun flag.
`timescale 1ns/1ps
module nlc_ch_scheduler #(
  parameter int NCH    = 2,
  parameter int XW     = 21,
  parameter int NCOEFF = 11,
  parameter int CS_LAT = 2,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int LW    = (CS_LAT > 1) ? $clog2(CS_LAT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    srdyi,
  input  logic [NCH*XW-1:0] x_adc,
  output logic              core_srdyi,
  output logic [XW-1:0]     core_x_adc,
  output logic [3:0]        core_coeff_sel,
  output logic              core_sum_rst,
  output logic              core_sum_en,
  input  logic [XW-1:0]     core_x_lin,
  output logic [XW-1:0]     x_lin,
  output logic [NCH-1:0]    srdyo,
  output logic [CW-1:0]     ch_id,
  output logic [NCH-1:0]    overrun,
  output logic              busy
);

  // state | meaning
  // IDLE  | no evaluation in flight, waiting for a pending sample
  // LOAD  | start strobe and accumulator clear, granted sample on core_x_adc
  // WAIT  | CS_LAT cycles for center/scale to reach the Horner loop
  // EVAL  | NCOEFF Horner steps, coefficient index counting down to 0
  // DONE  | capture core result, raise srdyo for the owning channel
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, EVAL, DONE} state_t;

  state_t          state, state_nxt;
  logic [NCH-1:0]  pend;
  logic [XW-1:0]   hold [NCH];
  logic [XW-1:0]   x_load;
  logic [CW-1:0]   gnt, gnt_nxt, ptr;
  logic            gnt_vld;
  logic [LW-1:0]   wait_cnt;
  logic [3:0]      sel;
  logic            loading;

  assign loading        = (state == LOAD);
  assign busy           = (state != IDLE);
  assign ch_id          = gnt;
  assign core_coeff_sel = sel;
  // hold[gnt] may be overwritten after LOAD, so the presented sample is latched
  assign core_x_adc     = loading ? hold[gnt] : x_load;

  // first pending channel after the last grant, wrapping modulo NCH
  always_comb begin
    logic [CW-1:0] idx;
    gnt_nxt = gnt;
    gnt_vld = 1'b0;
    idx     = ptr;
    for (int k = 0; k < NCH; k++) begin
      idx = (idx == CW'(NCH-1)) ? '0 : idx + CW'(1);
      if (!gnt_vld && pend[idx]) begin
        gnt_nxt = idx;
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    core_srdyi   = 1'b0;
    core_sum_rst = 1'b0;
    core_sum_en  = 1'b0;
    case (state)
      IDLE: if (|pend) state_nxt = LOAD;
      LOAD: begin
        core_srdyi   = 1'b1;
        core_sum_rst = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT: if (wait_cnt == '0) state_nxt = EVAL;
      EVAL: begin
        core_sum_en = 1'b1;
        if (sel == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = (|pend) ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt      <= '0;
      ptr      <= CW'(NCH-1);
      x_load   <= '0;
      wait_cnt <= '0;
      sel      <= 4'(NCOEFF-1);
      x_lin    <= '0;
      srdyo    <= '0;
    end else begin
      srdyo <= '0;
      if (state_nxt == LOAD && gnt_vld) begin
        gnt <= gnt_nxt;
        ptr <= gnt_nxt;
      end
      if (loading) begin
        x_load   <= hold[gnt];
        wait_cnt <= LW'(CS_LAT-1);
      end
      if (state == WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - LW'(1);
      if (state == EVAL) sel <= (sel == '0) ? 4'(NCOEFF-1) : sel - 4'd1;
      if (state == DONE) begin
        x_lin <= core_x_lin;
        srdyo <= NCH'(1) << gnt;
      end
    end
  end

  // a strobe landing on the LOAD cycle of its own channel refills the slot without loss
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend    <= '0;
      overrun <= '0;
      for (int i = 0; i < NCH; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (srdyi[i]) begin
          hold[i] <= x_adc[i*XW +: XW];
          pend[i] <= 1'b1;
          if (pend[i] && !(loading && gnt == CW'(i))) overrun[i] <= 1'b1;
        end else if (loading && gnt == CW'(i)) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_nlc_ch_scheduler.sv
// Bench for nlc_ch_scheduler: vector table, hand-written corner sequences and a
// randomized run against a slot/time-based reference model of the scheduler.
`timescale 1ns/1ps
module tb_nlc_ch_scheduler;
  localparam int NCH = 2, XW = 21, NCOEFF = 11, CS_LAT = 2;

  logic              clk = 1'b0, reset = 1'b0;
  logic [NCH-1:0]    srdyi = '0;
  logic [NCH*XW-1:0] x_adc = '0;
  logic              core_srdyi, core_sum_rst, core_sum_en, busy;
  logic [XW-1:0]     core_x_adc, core_x_lin, x_lin;
  logic [3:0]        core_coeff_sel;
  logic [NCH-1:0]    srdyo, overrun;
  logic [0:0]        ch_id;
  int                n_chk = 0, n_fail = 0;

  nlc_ch_scheduler #(.NCH(NCH), .XW(XW), .NCOEFF(NCOEFF), .CS_LAT(CS_LAT)) dut (
    .clk(clk), .reset(reset), .srdyi(srdyi), .x_adc(x_adc),
    .core_srdyi(core_srdyi), .core_x_adc(core_x_adc), .core_coeff_sel(core_coeff_sel),
    .core_sum_rst(core_sum_rst), .core_sum_en(core_sum_en), .core_x_lin(core_x_lin),
    .x_lin(x_lin), .srdyo(srdyo), .ch_id(ch_id), .overrun(overrun), .busy(busy));

  always #5 clk = ~clk;

  // core stand-in: result is a fixed function of the sample, scrambled while accumulating
  function automatic logic [XW-1:0] core_fn(input logic [XW-1:0] x);
    return {x[4:0], x[XW-1:5]} ^ 21'h0A5A5;
  endfunction
  assign core_x_lin = core_fn(core_x_adc) ^ {XW{core_sum_en}};

  typedef struct { int cyc; int ch; logic [XW-1:0] val; } evt_t;
  typedef struct {
    logic [1:0] req; logic [XW-1:0] x0, x1;
    int n_exp, ch_a, cyc_a, ch_b, cyc_b; bit detail;
  } vec_t;

  evt_t          sched[$], evts[$], m_q[$], ev;
  vec_t          vecs[5];
  logic          tr_srdyi[64], tr_rst[64], tr_en[64];
  logic [3:0]    tr_sel[64];
  logic [XW-1:0] tr_xadc[64];
  int            multi_hot, ch1_pulses, fr_n, fch;
  logic [XW-1:0] cur[NCH], rv;
  bit            m_valid[NCH];
  logic [XW-1:0] m_val[NCH], m_xlin;
  int            m_ptr, m_avail, m_load_cyc, m_load_ch, m_last_load;
  logic [NCH-1:0] m_ovr, r_srdyo;
  logic          r_load, found;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    srdyi = '0;
    repeat (n) tick();
    reset = 1'b1;
  endtask

  // cycle 0 is the call point; sched entries drive srdyi in their cycle, srdyo events are recorded
  task automatic run_seq(input int ncyc);
    evts.delete();
    multi_hot = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c < 64) begin
        tr_srdyi[c] = core_srdyi; tr_rst[c] = core_sum_rst; tr_en[c] = core_sum_en;
        tr_sel[c] = core_coeff_sel; tr_xadc[c] = core_x_adc;
      end
      if (srdyo != '0) begin
        ev.cyc = c; ev.ch = srdyo[1] ? 1 : 0; ev.val = x_lin;
        evts.push_back(ev);
        if (!$onehot(srdyo)) multi_hot++;
      end
      srdyi = '0;
      foreach (sched[k]) if (sched[k].cyc == c) begin
        srdyi[sched[k].ch] = 1'b1;
        x_adc[sched[k].ch*XW +: XW] = sched[k].val;
      end
      tick();
    end
    srdyi = '0;
    sched.delete();
  endtask

  task automatic push_stim(input int cyc, input int ch, input logic [XW-1:0] val);
    evt_t s;
    s.cyc = cyc; s.ch = ch; s.val = val;
    sched.push_back(s);
  endtask

  task automatic check_evt(input string name, input int idx, input int ch, input int cyc,
                           input logic [XW-1:0] val);
    if (idx >= evts.size()) begin
      n_chk++; n_fail++;
      $display("FAIL %s: got %0d results expected result #%0d", name, evts.size(), idx);
    end else begin
      check($sformatf("%s_ch", name), evts[idx].ch, ch);
      check($sformatf("%s_cyc", name), evts[idx].cyc, cyc);
      check($sformatf("%s_xlin", name), evts[idx].val, core_fn(val));
    end
  endtask

  initial begin
    vecs[0] = '{2'b01, 21'h00ABC, 21'h00000, 1, 0, 17, 0, 0, 1'b1};
    vecs[1] = '{2'b10, 21'h00000, 21'h1ABCD, 1, 1, 17, 0, 0, 1'b0};
    vecs[2] = '{2'b11, 21'h1F0F0, 21'h05555, 2, 0, 17, 1, 32, 1'b0};
    vecs[3] = '{2'b00, 21'h12345, 21'h0F00F, 0, 0, 0, 0, 0, 1'b0};
    vecs[4] = '{2'b01, 21'h1FFFFF, 21'h00000, 1, 0, 17, 0, 0, 1'b0};

    // reset held with srdyi toggling
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      srdyi = 2'(i + 1);
      x_adc = {NCH*XW{1'b1}};
      tick();
    end
    check("rst_core_srdyi", core_srdyi, 0);
    check("rst_sum_rst", core_sum_rst, 0);
    check("rst_sum_en", core_sum_en, 0);
    check("rst_coeff_sel", core_coeff_sel, 10);
    check("rst_busy", busy, 0);
    check("rst_srdyo", srdyo, 0);
    check("rst_x_lin", x_lin, 0);
    check("rst_overrun", overrun, 0);
    check("rst_ch_id", ch_id, 0);
    check("rst_core_x_adc", core_x_adc, 0);
    srdyi = '0;
    reset = 1'b1;
    fr_n = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy || srdyo != '0) fr_n++;
      tick();
    end
    check("rst_idle_stays", fr_n, 0);

    // vector table
    foreach (vecs[v]) begin
      do_reset(2);
      for (int ch = 0; ch < NCH; ch++)
        if (vecs[v].req[ch]) push_stim(0, ch, (ch == 0) ? vecs[v].x0 : vecs[v].x1);
      run_seq(40);
      check($sformatf("v%0d_nres", v), evts.size(), vecs[v].n_exp);
      check($sformatf("v%0d_multihot", v), multi_hot, 0);
      if (vecs[v].n_exp >= 1)
        check_evt($sformatf("v%0d_a", v), 0, vecs[v].ch_a, vecs[v].cyc_a,
                  (vecs[v].ch_a == 0) ? vecs[v].x0 : vecs[v].x1);
      if (vecs[v].n_exp >= 2)
        check_evt($sformatf("v%0d_b", v), 1, vecs[v].ch_b, vecs[v].cyc_b,
                  (vecs[v].ch_b == 0) ? vecs[v].x0 : vecs[v].x1);
      if (vecs[v].detail) begin
        for (int c = 1; c <= 17; c++) begin
          check($sformatf("v%0d_core_srdyi_c%0d", v, c), tr_srdyi[c], c == 2);
          check($sformatf("v%0d_sum_rst_c%0d", v, c), tr_rst[c], c == 2);
          check($sformatf("v%0d_sum_en_c%0d", v, c), tr_en[c], (c >= 5 && c <= 15));
          if (c >= 5 && c <= 15)
            check($sformatf("v%0d_coeff_sel_c%0d", v, c), tr_sel[c], 15 - c);
        end
        check($sformatf("v%0d_core_x_adc", v), tr_xadc[2], vecs[v].x0);
      end
    end

    // overrun: channel 1 rewritten while channel 0 evaluates
    do_reset(2);
    push_stim(0, 0, 21'h0A0A0);
    push_stim(0, 1, 21'h11111);
    push_stim(5, 1, 21'h16789);
    run_seq(45);
    check("ovr_nres", evts.size(), 2);
    check_evt("ovr_ch0", 0, 0, 17, 21'h0A0A0);
    check_evt("ovr_ch1", 1, 1, 32, 21'h16789);
    check("ovr_flag", overrun, 2'b10);
    ch1_pulses = 0;
    foreach (evts[k]) if (evts[k].ch == 1) ch1_pulses++;
    check("ovr_ch1_pulses", ch1_pulses, 1);

    // strobe on the LOAD cycle of the same channel: kept, no overrun
    do_reset(2);
    push_stim(0, 0, 21'h0C0DE);
    push_stim(2, 0, 21'h1BEEF);
    run_seq(40);
    check("ldcoll_nres", evts.size(), 2);
    check_evt("ldcoll_first", 0, 0, 17, 21'h0C0DE);
    check_evt("ldcoll_second", 1, 0, 32, 21'h1BEEF);
    check("ldcoll_overrun", overrun, 0);

    // fairness: each channel refilled right after its result
    do_reset(2);
    cur[0] = 21'h00011;
    cur[1] = 21'h10022;
    fr_n = 0;
    for (int c = 0; c < 125; c++) begin
      srdyi = '0;
      if (c == 0) begin
        srdyi = 2'b11;
        x_adc = {cur[1], cur[0]};
      end
      if (srdyo != '0) begin
        fch = srdyo[1] ? 1 : 0;
        check($sformatf("rr_grant%0d", fr_n), fch, fr_n % 2);
        check($sformatf("rr_xlin%0d", fr_n), x_lin, core_fn(cur[fch]));
        cur[fch] = cur[fch] + 21'h01357;
        srdyi[fch] = 1'b1;
        x_adc[fch*XW +: XW] = cur[fch];
        fr_n++;
      end
      tick();
    end
    srdyi = '0;
    check("rr_nres", fr_n, 8);
    check("rr_overrun", overrun, 0);

    // reset during EVAL abandons the sample
    do_reset(2);
    push_stim(0, 0, 21'h05A5A);
    run_seq(9);
    check("mid_in_eval", core_sum_en, 1);
    reset = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_sum_en", core_sum_en, 0);
    check("mid_coeff_sel", core_coeff_sel, 10);
    check("mid_core_x_adc", core_x_adc, 0);
    repeat (2) tick();
    reset = 1'b1;
    run_seq(30);
    check("mid_no_srdyo", evts.size(), 0);
    push_stim(0, 1, 21'h13579);
    run_seq(25);
    check("mid_after_nres", evts.size(), 1);
    check_evt("mid_after", 0, 1, 17, 21'h13579);

    // randomized run against the reference model
    do_reset(2);
    for (int i = 0; i < NCH; i++) begin m_valid[i] = 0; m_val[i] = '0; end
    m_ptr = NCH - 1; m_avail = 0; m_load_cyc = -1; m_load_ch = 0; m_last_load = -100;
    m_ovr = '0; m_xlin = '0; m_q.delete();
    for (int c = 0; c < 900; c++) begin
      r_load = (c == m_load_cyc);
      if (r_load) begin
        ev.cyc = c + 15; ev.ch = m_load_ch; ev.val = m_val[m_load_ch];
        m_q.push_back(ev);
        m_valid[m_load_ch] = 0;
        m_last_load = c;
      end
      r_srdyo = '0;
      if (m_q.size() > 0 && m_q[0].cyc == c) begin
        r_srdyo[m_q[0].ch] = 1'b1;
        m_xlin = core_fn(m_q[0].val);
        void'(m_q.pop_front());
      end
      check($sformatf("rnd_srdyo_c%0d", c), srdyo, r_srdyo);
      check($sformatf("rnd_xlin_c%0d", c), x_lin, m_xlin);
      check($sformatf("rnd_overrun_c%0d", c), overrun, m_ovr);
      check($sformatf("rnd_busy_c%0d", c), busy, (c >= m_last_load && c <= m_last_load + 14));
      check($sformatf("rnd_core_srdyi_c%0d", c), core_srdyi, r_load);
      if (r_load) begin
        check($sformatf("rnd_ch_id_c%0d", c), ch_id, m_load_ch);
        check($sformatf("rnd_core_x_adc_c%0d", c), core_x_adc, m_val[m_load_ch]);
      end
      if (c >= m_avail) begin
        found = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
          if (!found && m_valid[(m_ptr + k) % NCH]) begin
            found = 1'b1;
            m_load_ch = (m_ptr + k) % NCH;
          end
        end
        if (found) begin
          m_ptr = m_load_ch;
          m_load_cyc = c + 1;
          m_avail = c + 15;
        end
      end
      srdyi = '0;
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(0, (c < 450) ? 24 : 7) == 0) begin
          rv = XW'($urandom);
          srdyi[ch] = 1'b1;
          x_adc[ch*XW +: XW] = rv;
          if (m_valid[ch]) m_ovr[ch] = 1'b1;
          m_valid[ch] = 1;
          m_val[ch] = rv;
        end
      end
      tick();
    end
    srdyi = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
